// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - USB full-speed receive control FSM
module usb_rx_ctrl #(
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic       tb_clk,
    input  logic       tb_n_rst,
    input  logic       d_edge,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic       eop,
    input  logic       buffer_full,
    output logic       rcving,
    output logic [2:0] rx_packet,
    output logic [7:0] rx_packet_data,
    output logic       store_rx_packet,
    output logic       r_error,
    output logic       packet_done,
    output logic [6:0] byte_count
);

    typedef enum logic [3:0] {
        IDLE, SYNC, PID, TOKEN, DATA, WAIT_EOP, DONE, ERR_WAIT, ERR_IDLE
    } state_t;

    state_t     state, state_n;
    logic [7:0] h0, h1, h0_n, h1_n;
    logic [1:0] hc, hc_n;
    logic       rcving_n, store_n, done_n, err_n;
    logic [2:0] pkt_n;
    logic [7:0] data_n;
    logic [6:0] cnt_n;

    always_ff @(posedge tb_clk or negedge tb_n_rst) begin
        if (!tb_n_rst) begin
            state           <= IDLE;
            h0              <= 8'd0;
            h1              <= 8'd0;
            hc              <= 2'd0;
            rcving          <= 1'b0;
            rx_packet       <= 3'd0;
            rx_packet_data  <= 8'd0;
            store_rx_packet <= 1'b0;
            r_error         <= 1'b0;
            packet_done     <= 1'b0;
            byte_count      <= 7'd0;
        end else begin
            state           <= state_n;
            h0              <= h0_n;
            h1              <= h1_n;
            hc              <= hc_n;
            rcving          <= rcving_n;
            rx_packet       <= pkt_n;
            rx_packet_data  <= data_n;
            store_rx_packet <= store_n;
            r_error         <= err_n;
            packet_done     <= done_n;
            byte_count      <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        h0_n     = h0;
        h1_n     = h1;
        hc_n     = hc;
        rcving_n = rcving;
        store_n  = 1'b0;
        done_n   = 1'b0;
        err_n    = r_error;
        pkt_n    = rx_packet;
        data_n   = rx_packet_data;
        cnt_n    = byte_count;

        case (state)
            IDLE, ERR_IDLE: begin
                if (d_edge) begin
                    state_n  = SYNC;
                    rcving_n = 1'b1;
                    err_n    = 1'b0;
                    cnt_n    = 7'd0;
                    hc_n     = 2'd0;
                    h0_n     = 8'd0;
                    h1_n     = 8'd0;
                end
            end
            SYNC: begin
                if (eop)
                    state_n = ERR_IDLE;
                else if (byte_received)
                    state_n = (rcv_data == 8'h80) ? PID : ERR_WAIT;
            end
            PID: begin
                if (eop) begin
                    state_n = ERR_IDLE;
                end else if (byte_received) begin
                    pkt_n   = 3'd0;
                    state_n = ERR_WAIT;
                    if (rcv_data[7:4] == ~rcv_data[3:0]) begin
                        case (rcv_data)
                            8'hE1:        begin pkt_n = 3'd1; state_n = TOKEN;    end
                            8'h69:        begin pkt_n = 3'd2; state_n = TOKEN;    end
                            8'hC3, 8'h4B: begin pkt_n = 3'd3; state_n = DATA;     end
                            8'hD2:        begin pkt_n = 3'd4; state_n = WAIT_EOP; end
                            8'h5A:        begin pkt_n = 3'd5; state_n = WAIT_EOP; end
                            8'h1E:        begin pkt_n = 3'd6; state_n = WAIT_EOP; end
                            default:      begin pkt_n = 3'd0; state_n = ERR_WAIT; end
                        endcase
                    end
                end
            end
            TOKEN: begin
                if (eop)
                    state_n = (hc == 2'd2) ? DONE : ERR_IDLE;
                else if (byte_received) begin
                    if (hc == 2'd2)
                        state_n = ERR_WAIT;
                    else
                        hc_n = hc + 2'd1;
                end
            end
            DATA: begin
                // The last two bytes held at eop are the CRC and never reach the FIFO.
                if (eop) begin
                    state_n = (hc == 2'd2) ? DONE : ERR_IDLE;
                end else if (byte_received) begin
                    h0_n = h1;
                    h1_n = rcv_data;
                    if (hc == 2'd2) begin
                        if (buffer_full || byte_count >= 7'(MAX_DATA_BYTES)) begin
                            state_n = ERR_WAIT;
                        end else begin
                            store_n = 1'b1;
                            data_n  = h0;
                            cnt_n   = byte_count + 7'd1;
                        end
                    end else begin
                        hc_n = hc + 2'd1;
                    end
                end
            end
            WAIT_EOP: begin
                if (eop)
                    state_n = DONE;
                else if (byte_received)
                    state_n = ERR_WAIT;
            end
            DONE:     state_n = IDLE;
            ERR_WAIT: if (eop) state_n = ERR_IDLE;
            default:  state_n = IDLE;
        endcase

        if (state_n == ERR_WAIT || state_n == ERR_IDLE)
            err_n = 1'b1;
        if (state_n == ERR_IDLE || state_n == IDLE)
            rcving_n = 1'b0;
        if (state_n == DONE)
            done_n = 1'b1;
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb/tb_usb_rx_ctrl.sv - directed scoreboard bench for usb_rx_ctrl
module tb_usb_rx_ctrl;

    logic       tb_clk = 1'b0;
    logic       tb_n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'd0;
    logic       eop = 1'b0;
    logic       buffer_full = 1'b0;
    logic       rcving;
    logic [2:0] rx_packet;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet;
    logic       r_error;
    logic       packet_done;
    logic [6:0] byte_count;

    int errors = 0;
    int checks = 0;
    int store_cnt = 0;
    int done_cnt = 0;
    int s0, d0;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;
    logic [7:0] pid_tab[3] = '{8'hE1, 8'h5A, 8'h1E};
    logic [7:0] typ_tab[3] = '{8'h01, 8'h05, 8'h06};

    usb_rx_ctrl #(.MAX_DATA_BYTES(64)) dut (
        .tb_clk(tb_clk), .tb_n_rst(tb_n_rst), .d_edge(d_edge),
        .byte_received(byte_received), .rcv_data(rcv_data), .eop(eop),
        .buffer_full(buffer_full), .rcving(rcving), .rx_packet(rx_packet),
        .rx_packet_data(rx_packet_data), .store_rx_packet(store_rx_packet),
        .r_error(r_error), .packet_done(packet_done), .byte_count(byte_count)
    );

    always #5 tb_clk = ~tb_clk;

    always @(negedge tb_clk) begin
        if (store_rx_packet) begin
            store_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_store observed=%0h expected=no_store", rx_packet_data);
            end
            if (sb.size() > 0) begin
                sb_exp = sb.pop_front();
                checks++;
                assert (rx_packet_data === sb_exp) else begin
                    errors++;
                    $error("FAIL sb_store_data observed=%0h expected=%0h", rx_packet_data, sb_exp);
                end
            end
        end
        if (packet_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic de, input logic br, input logic e, input logic bf,
                         input logic [7:0] b);
        d_edge = de; byte_received = br; eop = e; buffer_full = bf; rcv_data = b;
        @(posedge tb_clk); #1;
        d_edge = 1'b0; byte_received = 1'b0; eop = 1'b0; buffer_full = 1'b0;
    endtask

    task automatic start();                drive(1, 0, 0, 0, 8'h00); endtask
    task automatic send(input logic [7:0] b); drive(0, 1, 0, 0, b);  endtask
    task automatic end_pkt();              drive(0, 0, 1, 0, 8'h00); endtask
    task automatic tick();                 @(posedge tb_clk); #1;    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rcving"}, {7'd0, rcving}, 8'd0);
        chk({tag, "_rx_packet"}, {5'd0, rx_packet}, 8'd0);
        chk({tag, "_data"}, rx_packet_data, 8'd0);
        chk({tag, "_store"}, {7'd0, store_rx_packet}, 8'd0);
        chk({tag, "_r_error"}, {7'd0, r_error}, 8'd0);
        chk({tag, "_done"}, {7'd0, packet_done}, 8'd0);
        chk({tag, "_byte_count"}, {1'b0, byte_count}, 8'd0);
    endtask

    initial begin
        repeat (3) @(posedge tb_clk);
        #1;
        chk_all_zero("reset");
        tb_n_rst = 1'b1;
        tick();

        // nominal DATA0 with CRC stripping
        d0 = done_cnt; s0 = store_cnt;
        start();
        chk("d0_rcving", {7'd0, rcving}, 8'd1);
        send(8'h80); send(8'hC3);
        chk("d0_rx_packet", {5'd0, rx_packet}, 8'd3);
        send(8'h00);
        send(8'h01);
        chk("d0_no_store_early", {7'd0, store_rx_packet}, 8'd0);
        sb.push_back(8'h00); send(8'h02);
        chk("d0_store_on_3rd", {7'd0, store_rx_packet}, 8'd1);
        sb.push_back(8'h01); send(8'h03);
        sb.push_back(8'h02); send(8'hF7);
        sb.push_back(8'h03); send(8'h5E);
        end_pkt();
        chk("d0_done_pulse", {7'd0, packet_done}, 8'd1);
        tick();
        chk("d0_done_clear", {7'd0, packet_done}, 8'd0);
        chk("d0_rcving_off", {7'd0, rcving}, 8'd0);
        chk("d0_byte_count", {1'b0, byte_count}, 8'd4);
        chk("d0_r_error", {7'd0, r_error}, 8'd0);
        chk("d0_data_hold", rx_packet_data, 8'h03);
        chk("d0_stores", 8'(store_cnt - s0), 8'd4);
        chk("d0_dones", 8'(done_cnt - d0), 8'd1);
        chk("d0_sb_drained", 8'(sb.size()), 8'd0);

        // asynchronous reset in the middle of a data packet
        d0 = done_cnt;
        start(); send(8'h80); send(8'hC3); send(8'h10); send(8'h11);
        sb.push_back(8'h10); send(8'h12);
        @(negedge tb_clk); #1;
        tb_n_rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        chk_all_zero("rst_next");
        tb_n_rst = 1'b1;
        tick();
        chk("rst_no_done", 8'(done_cnt - d0), 8'd0);

        // ACK handshake after reset
        d0 = done_cnt;
        start(); send(8'h80); send(8'hD2);
        chk("ack_rx_packet", {5'd0, rx_packet}, 8'd4);
        end_pkt();
        chk("ack_done", {7'd0, packet_done}, 8'd1);
        tick();

        // IN token, then IN token with an extra byte
        s0 = store_cnt;
        start(); send(8'h80); send(8'h69);
        chk("in_rx_packet", {5'd0, rx_packet}, 8'd2);
        send(8'hA5); send(8'h5A); end_pkt();
        chk("in_done", {7'd0, packet_done}, 8'd1);
        tick();
        chk("in_no_stores", 8'(store_cnt - s0), 8'd0);
        d0 = done_cnt;
        start(); send(8'h80); send(8'h69); send(8'h01); send(8'h02); send(8'h03);
        chk("in3_r_error", {7'd0, r_error}, 8'd1);
        end_pkt(); tick();
        chk("in3_no_done", 8'(done_cnt - d0), 8'd0);
        chk("in3_rcving", {7'd0, rcving}, 8'd0);

        // other PID decodes
        for (int i = 0; i < 3; i++) begin
            start(); send(8'h80); send(pid_tab[i]);
            chk("pid_table", {5'd0, rx_packet}, typ_tab[i]);
            end_pkt(); tick();
        end

        // bad PID check nibbles
        start(); send(8'h80); send(8'hC4);
        chk("badpid_rx_packet", {5'd0, rx_packet}, 8'd0);
        end_pkt(); tick();
        chk("badpid_r_error", {7'd0, r_error}, 8'd1);
        chk("badpid_rcving", {7'd0, rcving}, 8'd0);

        // bad SYNC, then r_error clears on the next packet start
        s0 = store_cnt;
        start(); send(8'h81);
        chk("badsync_r_error", {7'd0, r_error}, 8'd1);
        send(8'h22); end_pkt(); tick();
        start();
        chk("badsync_clear", {7'd0, r_error}, 8'd0);
        end_pkt();
        chk("sync_eop_err", {7'd0, r_error}, 8'd1);
        chk("badsync_no_stores", 8'(store_cnt - s0), 8'd0);

        // DATA1 with buffer_full on the first due store
        s0 = store_cnt; d0 = done_cnt;
        start(); send(8'h80); send(8'h4B);
        chk("d1_rx_packet", {5'd0, rx_packet}, 8'd3);
        send(8'hAA); send(8'hBB);
        drive(0, 1, 0, 1, 8'hCC);
        chk("d1_full_no_store", {7'd0, store_rx_packet}, 8'd0);
        chk("d1_full_r_error", {7'd0, r_error}, 8'd1);
        send(8'hDD); send(8'hEE); end_pkt(); tick();
        chk("d1_no_stores", 8'(store_cnt - s0), 8'd0);
        chk("d1_no_done", 8'(done_cnt - d0), 8'd0);

        // eop wins over a simultaneous byte
        s0 = store_cnt;
        start(); send(8'h80); send(8'hC3); send(8'h11); send(8'h22);
        sb.push_back(8'h11); send(8'h33);
        drive(0, 1, 1, 0, 8'h44);
        chk("both_no_store", {7'd0, store_rx_packet}, 8'd0);
        chk("both_done", {7'd0, packet_done}, 8'd1);
        chk("both_count", {1'b0, byte_count}, 8'd1);
        tick();
        chk("both_stores", 8'(store_cnt - s0), 8'd1);

        // payload length limit
        s0 = store_cnt;
        start(); send(8'h80); send(8'hC3);
        for (int i = 0; i < 66; i++) begin
            if (i >= 2) sb.push_back(8'(i - 2));
            send(8'(i));
        end
        chk("max_count", {1'b0, byte_count}, 8'd64);
        chk("max_no_err", {7'd0, r_error}, 8'd0);
        send(8'hFF);
        chk("max_over_store", {7'd0, store_rx_packet}, 8'd0);
        chk("max_over_err", {7'd0, r_error}, 8'd1);
        chk("max_sat", {1'b0, byte_count}, 8'd64);
        end_pkt(); tick();
        chk("max_stores", 8'(store_cnt - s0), 8'd64);
        chk("sb_final", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
Control FSM for the USB full-speed receive path. It consumes byte strobes and EOP strobes from the decoder/shift-register front end and performs these checks and actions:
- Validates SYNC and PID.
- Classifies the packet.
- Tracks token and data payload length.
- Strips the 2-byte CRC16 from data packets through a 2-byte hold line.
- Issues store strobes to the RX FIFO and flags protocol errors.
It sits between the USB RX bit-level datapath and the RX data buffer / protocol layer.

Parameters:
MAX_DATA_BYTES, 64, maximum payload bytes stored per data packet (excluding CRC).

Ports:
tb_clk  input  1  system clock
tb_n_rst  input  1  reset, asynchronous, active-low
d_edge  input  1  1-cycle pulse: first line transition after idle (packet start)
byte_received  input  1  1-cycle pulse: rcv_data holds a complete unstuffed byte
rcv_data  input  8  received byte, LSB first on line
eop  input  1  1-cycle pulse: end-of-packet (SE0 + J) detected
buffer_full  input  1  RX FIFO cannot accept a store this cycle
rcving  output  1  high from packet start until DONE/ERR_WAIT exit
rx_packet  output  3  packet type: 000 none, 001 OUT, 010 IN, 011 DATA0/1, 100 ACK, 101 NAK, 110 STALL
rx_packet_data  output  8  byte presented with store_rx_packet
store_rx_packet  output  1  1-cycle write strobe to RX FIFO
r_error  output  1  sticky protocol error flag
packet_done  output  1  1-cycle pulse on successful packet end
byte_count  output  7  payload bytes stored in current packet

Behaviour:
- Reset values:
  - All outputs 0.
  - Hold line empty.
  - State IDLE.
  - Reset mid-packet aborts with no store or done pulses.
- All outputs are registered. Response appears the cycle after the triggering strobe.
- Priority: eop beats byte_received in the same cycle. The byte is discarded and eop is evaluated against the current state.
- IDLE:
  - d_edge -> SYNC.
  - Set rcving; clear r_error, byte_count and hold line.
- SYNC:
  - byte_received with 0x80 -> PID.
  - Any other byte -> ERR_WAIT.
  - eop -> ERR_IDLE.
- PID:
  - byte_received: require rcv_data[7:4] == ~rcv_data[3:0], else error.
  - Decode:
    - 0xE1 -> 001
    - 0x69 -> 010
    - 0xC3 or 0x4B -> 011
    - 0xD2 -> 100
    - 0x5A -> 101
    - 0x1E -> 110
    - Other -> rx_packet=000, ERR_WAIT.
  - Next state: token -> TOKEN; data -> DATA; handshake -> WAIT_EOP.
  - rx_packet updates only here and holds until the next PID decode.
  - eop -> ERR_IDLE.
- TOKEN:
  - Counts bytes.
  - A 3rd byte -> ERR_WAIT.
  - eop with count==2 -> DONE; count!=2 -> ERR_IDLE.
- DATA:
  - 2-byte hold line. Each byte_received does h0<=h1, h1<=rcv_data.
  - If the hold line was already full, the old h0 is emitted: rx_packet_data<=h0, store_rx_packet=1, byte_count+1.
  - If a store is due and buffer_full=1 -> ERR_WAIT, no store.
  - If a store would exceed MAX_DATA_BYTES -> ERR_WAIT.
  - eop with hold line full -> DONE; the two held bytes are CRC and are discarded.
  - eop with fewer than 2 held bytes -> ERR_IDLE.
- WAIT_EOP: byte_received -> ERR_WAIT; eop -> DONE.
- DONE: packet_done=1 for one cycle, rcving=0 -> IDLE.
- ERR_WAIT: r_error=1, ignore bytes; eop -> ERR_IDLE.
- ERR_IDLE:
  - r_error stays 1, rcving=0.
  - d_edge -> SYNC, which clears r_error.
- No CRC arithmetic is checked here; CRC is only length-stripped.
- byte_count saturates at MAX_DATA_BYTES.
- rx_packet_data holds its last stored value between strobes.

Test Plan:
1. Reset mid-DATA (after 3 payload bytes) -> all outputs 0 next cycle, no packet_done, FSM accepts new packet after d_edge.
2. Nominal DATA0: d_edge, bytes 80,C3,00,01,02,03,F7,5E, eop.
   - Expected: rx_packet=011 after PID.
   - 4 store strobes with data 00,01,02,03, each issued on the byte_received of bytes 02,03,F7,5E respectively.
   - byte_count=4, packet_done pulse 1 cycle after eop, r_error=0.
3. IN token: 80,69,byte A,byte B, eop -> rx_packet=010, no stores, packet_done pulse. Same with a 3rd byte -> r_error=1, no packet_done.
4. Handshake ACK: 80,D2, eop -> rx_packet=100, packet_done. Bad PID 0xC4 -> rx_packet=000, r_error=1 after eop, rcving=0.
5. Bad sync 0x81 -> r_error=1, no stores; next d_edge clears r_error.
6. DATA1 with buffer_full=1 at the 3rd payload byte -> exactly 0 stores after the failed one, r_error=1. eop in the same cycle as byte_received -> byte dropped.
